// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch front end. It owns the fetch PC and reads the combinational
//   instruction memory. Fetched words go into a DEPTH-entry prefetch queue, and the
//   queue head is handed to decode under a valid/stall handshake. A redirect from
//   decode flushes the queue and restarts fetching at the target.
//
// Ports
//   clk            in   system clock; all state updates on the rising edge
//   reset          in   synchronous active-high reset (wins over redirect)
//   redirect_valid in   redirect request from decode (flush + new fetch PC)
//   redirect_pc    in   redirect target; the two low bits are ignored
//   stall_f        in   blocks new fetches (pushes) this cycle
//   stall_d        in   decode not accepting this cycle (blocks pops)
//   imem_addr      out  word address of the current fetch PC
//   imem_rdata     in   instruction word for imem_addr (combinational)
//   instr_valid    out  queue head holds a valid instruction
//   instr          out  queue head instruction (0 when empty)
//   pc_plus4       out  queue head PC + 4 (0 when empty)
//   occupancy      out  number of entries currently held
module fetch_queue_unit #(
   parameter int               XLEN     = 32,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         redirect_valid,
   input  logic [XLEN-1:0]              redirect_pc,
   input  logic                         stall_f,
   input  logic                         stall_d,
   output logic [XLEN-3:0]              imem_addr,
   input  logic [31:0]                  imem_rdata,
   output logic                         instr_valid,
   output logic [31:0]                  instr,
   output logic [XLEN-1:0]              pc_plus4,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   // Queue storage: each entry holds the instruction and its PC + 4.
   logic [31:0]     instr_mem_q [DEPTH];
   logic [XLEN-1:0] pc4_mem_q   [DEPTH];

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

   logic            pop;
   logic            push;
   logic [XLEN-1:0] pc_inc;

   // The redirect target is word aligned, so its two low bits are never read.
   logic            unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign instr_valid = (occ_q != '0);
   assign occupancy   = occ_q;
   assign imem_addr   = fetch_pc_q[XLEN-1:2];
   // Gate the head with valid so that stale storage never shows while the queue is empty.
   assign instr       = instr_valid ? instr_mem_q[head_q] : 32'h0;
   assign pc_plus4    = instr_valid ? pc4_mem_q[head_q]   : '0;

   assign pc_inc = fetch_pc_q + XLEN'(4);
   assign pop    = instr_valid & ~stall_d & ~redirect_valid;
   // A full queue can still accept a push when it pops in the same cycle.
   assign push   = ~stall_f & ~redirect_valid & ((occ_q < OW'(DEPTH)) | pop);

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      occ_d      = occ_q;
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         head_d     = '0;
         tail_d     = '0;
         occ_d      = '0;
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      end else begin
         if (pop) begin
            head_d = head_q + PW'(1);
         end
         if (push) begin
            tail_d     = tail_q + PW'(1);
            fetch_pc_d = pc_inc;
         end
         case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
         fetch_pc_q <= RESET_PC;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[tail_q] <= imem_rdata;
         pc4_mem_q[tail_q]   <= pc_inc;
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
//   Drives fetch_queue_unit with directed and random stall/redirect/reset traffic.
//   A behavioural model tracks the fetch PC and queue contents. Each modelled fetch
//   pushes its expected {instr, pc+4} onto a scoreboard. A monitor pops that
//   scoreboard whenever the DUT hands an instruction to decode and compares it.
module tb_fetch_queue_unit;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stall_f = 1'b0;
   logic        stall_d = 1'b0;
   logic [29:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc_plus4;
   logic [2:0]  occupancy;

   int checks = 0;
   int errors = 0;

   // Expected instruction/PC+4 pairs, in the order decode should receive them.
   logic [63:0] sb_q[$];
   // Reference model state.
   int          mdl_cnt = 0;
   logic [31:0] mdl_pc  = RESET_PC;

   always #5 clk = ~clk;

   // Instruction memory: imem[i] = i.
   assign imem_rdata = {2'b00, imem_addr};

   fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .pc_plus4       (pc_plus4),
      .occupancy      (occupancy)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return {2'b00, pc[31:2]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance the reference model by one clock edge using the inputs just driven.
   task automatic model_step();
      bit mpop, mpush;
      if (reset) begin
         mdl_cnt = 0;
         mdl_pc  = RESET_PC;
         sb_q.delete();
      end else if (redirect_valid) begin
         mdl_cnt = 0;
         mdl_pc  = {redirect_pc[31:2], 2'b00};
         sb_q.delete();
      end else begin
         mpop  = (mdl_cnt > 0) && !stall_d;
         mpush = !stall_f && ((mdl_cnt < DEPTH) || mpop);
         if (mpush) begin
            sb_q.push_back({mem_word(mdl_pc), mdl_pc + 32'd4});
            mdl_pc = mdl_pc + 32'd4;
         end
         mdl_cnt = mdl_cnt + int'(mpush) - int'(mpop);
      end
   endtask

   // Drive inputs on the falling edge, then step the model at the rising edge.
   task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc,
                        input logic sf, input logic sd);
      @(negedge clk);
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      stall_f        = sf;
      stall_d        = sd;
      @(posedge clk);
      model_step();
   endtask

   task automatic run(input int n, input logic sf, input logic sd);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, sf, sd);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   // Monitor: sample mid-cycle, compare state to the model, and consume a
   // scoreboard entry on every accepted instruction.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #1;
         check("occupancy", 64'(occupancy), 64'(mdl_cnt));
         check("instr_valid", 64'(instr_valid), 64'(mdl_cnt != 0));
         check("imem_addr", 64'(imem_addr), 64'(mdl_pc[31:2]));
         if (!instr_valid) begin
            check("empty_instr", 64'(instr), 64'h0);
            check("empty_pc_plus4", 64'(pc_plus4), 64'h0);
         end
         if (instr_valid && !stall_d && !redirect_valid && !reset) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop actual=%0h required=none", instr);
            end else begin
               e = sb_q.pop_front();
               check("pop_instr", 64'(instr), 64'(e[63:32]));
               check("pop_pc_plus4", 64'(pc_plus4), 64'(e[31:0]));
               $display("pop instr=%08h pc_plus4=%08h occ=%0d", instr, pc_plus4, occupancy);
            end
         end
      end
   end

   initial begin
      int          r;
      logic        rst, rv, sf, sd;
      logic [31:0] rpc;

      // 1: reset then free-run
      do_reset();
      #1;
      check("t1_reset_valid", 64'(instr_valid), 64'h0);
      check("t1_reset_occ", 64'(occupancy), 64'h0);
      check("t1_reset_instr", 64'(instr), 64'h0);
      check("t1_reset_pc4", 64'(pc_plus4), 64'h0);
      check("t1_reset_addr", 64'(imem_addr), 64'(RESET_PC[31:2]));
      run(1, 1'b0, 1'b0);
      #1;
      check("t1_first_valid", 64'(instr_valid), 64'h1);
      check("t1_first_instr", 64'(instr), 64'h0);
      check("t1_first_pc4", 64'(pc_plus4), 64'h4);
      run(8, 1'b0, 1'b0);

      // 2: decode stalled for 10 cycles
      do_reset();
      run(10, 1'b0, 1'b1);
      #1;
      check("t2_occ_full", 64'(occupancy), 64'(DEPTH));
      check("t2_addr_held", 64'(imem_addr), 64'h4);
      run(8, 1'b0, 1'b0);

      // 3: redirect with 3 entries queued
      do_reset();
      run(3, 1'b0, 1'b1);
      #1;
      check("t3_occ3", 64'(occupancy), 64'h3);
      cycle(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
      #1;
      check("t3_occ0", 64'(occupancy), 64'h0);
      check("t3_addr", 64'(imem_addr), 64'h40);
      check("t3_not_valid", 64'(instr_valid), 64'h0);
      run(1, 1'b0, 1'b0);
      #1;
      check("t3_valid", 64'(instr_valid), 64'h1);
      check("t3_instr", 64'(instr), 64'h40);
      check("t3_pc4", 64'(pc_plus4), 64'h104);
      run(3, 1'b0, 1'b0);

      // 4: full queue streaming at full rate
      do_reset();
      run(DEPTH, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         run(1, 1'b0, 1'b0);
         #1;
         check("t4_occ_full", 64'(occupancy), 64'(DEPTH));
      end

      // 5: fetch stalled drains two queued entries
      do_reset();
      run(2, 1'b0, 1'b1);
      run(2, 1'b1, 1'b0);
      #1;
      check("t5_valid", 64'(instr_valid), 64'h0);
      check("t5_occ", 64'(occupancy), 64'h0);
      check("t5_addr", 64'(imem_addr), 64'h2);

      // 6: reset and redirect together on a full queue
      run(DEPTH, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
      #1;
      check("t6_occ", 64'(occupancy), 64'h0);
      check("t6_valid", 64'(instr_valid), 64'h0);
      check("t6_addr", 64'(imem_addr), 64'(RESET_PC[31:2]));

      // PC wrap at the top of the address space
      cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run(1, 1'b0, 1'b0);
      #1;
      check("wrap_instr", 64'(instr), 64'h3FFF_FFFF);
      check("wrap_pc4", 64'(pc_plus4), 64'h0);
      check("wrap_addr", 64'(imem_addr), 64'h0);
      run(3, 1'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         r   = int'($urandom_range(0, 99));
         rst = (r < 1);
         rv  = (r >= 1) && (r < 7);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                           : $urandom;
         sf  = ($urandom_range(0, 99) < 30);
         sd  = ($urandom_range(0, 99) < 35);
         cycle(rst, rv, rpc, sf, sd);
      end
      run(DEPTH + 2, 1'b1, 1'b0);

      @(negedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
